tug_field: RTL
==============

# tug_field

Parametrised tug-of-war playfield that replaces the per-light center/normal light cells with a single position register driving an N-light one-hot bar. It takes the two players' synchronized button levels, detects rising edges internally, moves the lit position, declares the round winner and keeps per-player saturating scores. It sits between the input synchronizers and the LED/HEX display drivers in the top level.

## Interface
- N, 9: number of playfield lights; odd, ≥3; center index C = (N-1)/2
- SCORE_W, 3: score counter width; maximum score SMAX = 2^SCORE_W - 1
- Clock  input  1  system clock, all state updates on rising edge
- Reset  input  1  synchronous, active-high
- L  input  1  left player button level, already synchronized, active-high
- R  input  1  right player button level, already synchronized, active-high
- Restart  input  1  level; starts a new round (recenter) when sampled high
- lights  output  N  one-hot playfield; bit N-1 is leftmost
- winner_l  output  1  high while in WIN_L
- winner_r  output  1  high while in WIN_R
- score_l  output  SCORE_W  left rounds won
- score_r  output  SCORE_W  right rounds won
- match_over  output  1  high when score_l or score_r equals SMAX

## Operation
- Edge detect: pl = L & ~L_d, pr = R & ~R_d. L_d/R_d load L/R every edge, including during Reset, so a button held through reset is not counted as a press.
- States: PLAY, WIN_L, WIN_R. Position register pos in 0..N-1. lights = (1 << pos) in PLAY, all zero in WIN_*.
- PLAY with pl & ~pr: if pos == N-1, go to WIN_L and score_l += 1 (saturate at SMAX). Otherwise pos += 1.
- PLAY with pr & ~pl: if pos == 0, go to WIN_R and score_r += 1 (saturate). Otherwise pos -= 1.
- PLAY with pl & pr: simultaneous presses cancel; no change.
- WIN_L/WIN_R: presses are ignored. The state holds until Restart.
- Restart sampled high and match_over low, from any state: go to PLAY with pos = C. Scores are kept. Restart has priority over a same-cycle press.
- Restart while match_over is high: ignored. The block stays in its current state and only Reset clears it.
- Reset: state PLAY, pos = C, scores 0.
- Scores never wrap. A win at SMAX leaves the score at SMAX; this cannot occur in normal flow because match_over blocks Restart.

## Timing
- Reset values: lights = 1<<C, winner_l = winner_r = 0, score_l = score_r = 0, match_over = 0.
- Press latency: L first sampled high at edge k (L_d = 0) → pos/lights updated at edge k. Visible one cycle after L rises before edge k.
- A held button produces exactly one move. The next move needs L low for at least one sampled edge.
- Win: the press at the edge light updates state, winner flag, score and lights = 0 all at the same edge k. match_over is combinational from the scores, so it is valid in the same cycle.
- Restart: sampled at edge k → lights = 1<<C and winner flags = 0 after edge k.
- Reset mid-round or in WIN_*: everything is at reset values after the reset edge, regardless of other inputs.

## Test plan
- Reset with L held high, then release and hold low 2 cycles → lights stays 1<<4 (N=9); no move counted.
- Five single-cycle L pulses from center (N=9) → pos 5,6,7,8, then the fifth pulse gives lights = 0, winner_l = 1, score_l = 1. Further L/R pulses → no change.
- L and R rising on the same edge at pos 4 → lights unchanged. L held for 10 cycles → exactly one step to pos 5.
- In WIN_R, pulse Restart together with an L rising edge → PLAY, lights = 1<<4, winner_r = 0, score_r kept, L press ignored.
- SCORE_W=2: left wins 3 rounds with Restart between → score_l = 3, match_over = 1. Restart → ignored, winner_l stays 1. Reset → all outputs at reset values.
- Mid-round at pos 2 with score_r = 1, assert Reset one cycle → lights = 1<<4, scores 0 on the next cycle.

Source files
------------

// File: rtl/tug_field_if.sv
// Playfield bus: player buttons and restart in,
// light bar, winner flags and scores out.
interface tug_field_if #(
  parameter int N       = 9,
  parameter int SCORE_W = 3
);
  logic               L;
  logic               R;
  logic               Restart;
  logic [N-1:0]       lights;
  logic               winner_l;
  logic               winner_r;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               match_over;

  modport master (
    output L, R, Restart,
    input  lights, winner_l, winner_r,
    input  score_l, score_r, match_over
  );

  modport slave (
    input  L, R, Restart,
    output lights, winner_l, winner_r,
    output score_l, score_r, match_over
  );
endinterface

// File: rtl/tug_field.sv
// Tug-of-war playfield: one position register drives an
// N-light one-hot bar, with round winner and saturating scores.
module tug_field #(
  parameter int N       = 9,
  parameter int SCORE_W = 3
) (
  input logic       Clock,
  input logic       Reset,
  tug_field_if.slave bus
);
  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] CTR = PW'((N - 1) / 2);
  localparam logic [PW-1:0] TOP = PW'(N - 1);
  localparam logic [N-1:0] CBAR = N'(1) << CTR;
  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

  typedef enum logic [1:0] {
    PLAY,
    WIN_L,
    WIN_R
  } state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic          l_d;
  logic          r_d;
  logic          pl;
  logic          pr;

  assign pl = bus.L & ~l_d;
  assign pr = bus.R & ~r_d;

  assign bus.match_over = (bus.score_l == SMAX)
                        | (bus.score_r == SMAX);

  always_ff @(posedge Clock) begin
    // Delay regs load through reset so a held button is not a press
    l_d <= bus.L;
    r_d <= bus.R;
    if (Reset) begin
      state        <= PLAY;
      pos          <= CTR;
      bus.lights   <= CBAR;
      bus.winner_l <= 1'b0;
      bus.winner_r <= 1'b0;
      bus.score_l  <= '0;
      bus.score_r  <= '0;
    end else if (bus.Restart && !bus.match_over) begin
      state        <= PLAY;
      pos          <= CTR;
      bus.lights   <= CBAR;
      bus.winner_l <= 1'b0;
      bus.winner_r <= 1'b0;
    end else begin
      case (state)
        PLAY: begin
          if (pl && !pr) begin
            if (pos == TOP) begin
              state        <= WIN_L;
              bus.lights   <= '0;
              bus.winner_l <= 1'b1;
              if (bus.score_l != SMAX)
                bus.score_l <= bus.score_l + ONE;
            end else begin
              pos        <= pos + PW'(1);
              bus.lights <= bus.lights << 1;
            end
          end else if (pr && !pl) begin
            if (pos == '0) begin
              state        <= WIN_R;
              bus.lights   <= '0;
              bus.winner_r <= 1'b1;
              if (bus.score_r != SMAX)
                bus.score_r <= bus.score_r + ONE;
            end else begin
              pos        <= pos - PW'(1);
              bus.lights <= bus.lights >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
